// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX operand stage: datapath widths, ALU op encoding
// and the hard-wired zero register index.
package riscv_pkg;

    localparam int unsigned XLEN   = 32'd32;
    localparam int unsigned REG_AW = 32'd5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/ex_fwd_unit.sv
// Operand forwarding select for one source register: EX/MEM beats MEM/WB beats
// the value captured from the register file; x0 is never forwarded.
module ex_fwd_unit #(
    parameter int unsigned XLEN   = 32'd32,
    parameter int unsigned REG_AW = 32'd5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   fwd_data
);

    logic exmem_hit_s;
    logic memwb_hit_s;

    assign exmem_hit_s = exmem_reg_write && (exmem_rd != {REG_AW{1'b0}}) && (exmem_rd == rs);
    assign memwb_hit_s = memwb_reg_write && (memwb_rd != {REG_AW{1'b0}}) && (memwb_rd == rs);

    // Priority select: the younger producer wins.
    always_comb begin
        fwd_data = reg_data;
        if (exmem_hit_s) begin
            fwd_data = exmem_result;
        end else if (memwb_hit_s) begin
            fwd_data = memwb_result;
        end else begin
            fwd_data = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and operand forwarding.
// Optional perf counters (stall_cnt, bubble_cnt) are built when EX_PERF_CNT_EN is defined.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32'd32,
    parameter int unsigned REG_AW = 32'd5
`ifdef EX_PERF_CNT_EN
   ,parameter int unsigned CNT_W  = 32'd32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_sel,
    input  logic              id_use_pc,
    input  logic              id_use_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_sel,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read
`ifdef EX_PERF_CNT_EN
   ,output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    import riscv_pkg::*;

    logic              valid_r;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   rs1_data_r;
    logic [XLEN-1:0]   rs2_data_r;
    logic [XLEN-1:0]   imm_r;
    logic [REG_AW-1:0] rs1_r;
    logic [REG_AW-1:0] rs2_r;
    logic [REG_AW-1:0] rd_r;
    alu_sel_e          alu_sel_r;
    logic              use_pc_r;
    logic              use_imm_r;
    logic              reg_write_r;
    logic              mem_read_r;

    logic              load_s;
    logic              hazard_s;
    logic [XLEN-1:0]   fwd_rs1_s;
    logic [XLEN-1:0]   fwd_rs2_s;

    assign load_s   = !valid_r || ex_ready;
    // Conservative: any source index matching the load's rd stalls, used or not.
    assign hazard_s = ex_mem_read && (rd_r != REG_AW'(REG_X0)) && id_valid
                      && ((id_rs1 == rd_r) || (id_rs2 == rd_r));
    assign id_ready = load_s && !hazard_s && !flush;

    // Pipeline register: flush, then bubble, then accept, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r     <= 1'b0;
            pc_r        <= {XLEN{1'b0}};
            rs1_data_r  <= {XLEN{1'b0}};
            rs2_data_r  <= {XLEN{1'b0}};
            imm_r       <= {XLEN{1'b0}};
            rs1_r       <= {REG_AW{1'b0}};
            rs2_r       <= {REG_AW{1'b0}};
            rd_r        <= {REG_AW{1'b0}};
            alu_sel_r   <= ALU_ADD;
            use_pc_r    <= 1'b0;
            use_imm_r   <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load_s && hazard_s) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r <= id_valid;
            if (id_valid) begin
                pc_r        <= id_pc;
                rs1_data_r  <= id_rs1_data;
                rs2_data_r  <= id_rs2_data;
                imm_r       <= id_imm;
                rs1_r       <= id_rs1;
                rs2_r       <= id_rs2;
                rd_r        <= id_rd;
                alu_sel_r   <= alu_sel_e'(id_alu_sel);
                use_pc_r    <= id_use_pc;
                use_imm_r   <= id_use_imm;
                reg_write_r <= id_reg_write;
                mem_read_r  <= id_mem_read;
            end
        end
    end

    ex_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs              (rs1_r),
        .reg_data        (rs1_data_r),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs1_s)
    );

    ex_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs              (rs2_r),
        .reg_data        (rs2_data_r),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs2_s)
    );

    assign ex_valid      = valid_r;
    assign alu_a         = use_pc_r  ? pc_r  : fwd_rs1_s;
    assign alu_b         = use_imm_r ? imm_r : fwd_rs2_s;
    assign alu_sel       = alu_sel_r;
    assign ex_store_data = fwd_rs2_s;
    assign ex_rd         = rd_r;
    assign ex_reg_write  = reg_write_r && valid_r;
    assign ex_mem_read   = mem_read_r && valid_r;

`ifdef EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic             bubble_evt_s;

    // A flush only counts when it kills a live entry.
    assign bubble_evt_s = flush ? valid_r : (load_s && hazard_s);

    // Free-running event counters, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (hazard_s) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (bubble_evt_s) begin
                bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized bench for id_ex_operand_stage against a behavioural model.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_sel;
    logic        id_use_pc, id_use_imm, id_reg_write, id_mem_read;
    logic        flush, ex_ready;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_sel;
    logic [4:0]  ex_rd;
`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
    int unsigned m_stall, m_bubble;
`endif

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  sel;
        logic        upc, uimm, rw, mr;
    } ent_t;

    ent_t m;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_sel(id_alu_sel),
        .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_ready(ex_ready),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read)
`ifdef EX_PERF_CNT_EN
       ,.stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_result;
        return regval;
    endfunction

    task automatic drive_idle();
        id_valid = 1'b0; id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_alu_sel = 4'd0;
        id_use_pc = 1'b0; id_use_imm = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        flush = 1'b0; ex_ready = 1'b1;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    task automatic model_reset();
        m = '0;
`ifdef EX_PERF_CNT_EN
        m_stall = 0; m_bubble = 0;
`endif
    endtask

    // Compare all outputs against the model, then advance model and DUT one clock.
    task automatic step();
        logic can, stall;
        ent_t nx;
        #1;
        can   = !m.v || ex_ready;
        stall = m.v && m.mr && (m.rd != 5'd0) && id_valid && (id_rs1 == m.rd || id_rs2 == m.rd);
        chk("id_ready", 32'(id_ready), 32'(can && !stall && !flush));
        chk("ex_valid", 32'(ex_valid), 32'(m.v));
        chk("alu_a", alu_a, m.upc ? m.pc : fwd(m.rs1, m.d1));
        chk("alu_b", alu_b, m.uimm ? m.imm : fwd(m.rs2, m.d2));
        chk("store_data", ex_store_data, fwd(m.rs2, m.d2));
        chk("alu_sel", 32'(alu_sel), 32'(m.sel));
        chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw && m.v));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr && m.v));
`ifdef EX_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);
        if (stall) m_stall++;
        if (flush ? m.v : (can && stall)) m_bubble++;
`endif
        nx = m;
        if (flush) nx.v = 1'b0;
        else if (can && stall) nx.v = 1'b0;
        else if (can) begin
            nx.v = id_valid;
            if (id_valid) begin
                nx.pc = id_pc; nx.d1 = id_rs1_data; nx.d2 = id_rs2_data; nx.imm = id_imm;
                nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd; nx.sel = id_alu_sel;
                nx.upc = id_use_pc; nx.uimm = id_use_imm; nx.rw = id_reg_write; nx.mr = id_mem_read;
            end
        end
        @(posedge clk);
        m = nx;
        #1;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and pass-through
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd4;
        id_rs1_data = 32'd1; id_rs2_data = 32'd2; id_alu_sel = 4'd0; id_reg_write = 1'b1;
        step();
        id_valid = 1'b0;
        #1 chk("pass_a", alu_a, 32'd1); chk("pass_b", alu_b, 32'd2); chk("pass_v", 32'(ex_valid), 32'd1);
        step();

        // Forwarding priority, then backpressure and flush while held
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_data = 32'd7; id_rs2 = 5'd0; id_rd = 5'd6; id_alu_sel = 4'd4;
        step();
        ex_ready = 1'b0; id_rd = 5'd9; id_alu_sel = 4'd1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA5555;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h00001234;
        #1 chk("fwd_exmem", alu_a, 32'hAAAA5555); chk("bp_ready", 32'(id_ready), 32'd0);
        exmem_rd = 5'd0;
        #1 chk("fwd_memwb", alu_a, 32'h00001234);
        step();
        chk("bp_rd_held", 32'(ex_rd), 32'd6); chk("bp_sel_held", 32'(alu_sel), 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_ready = 1'b1;
        chk("flush_v", 32'(ex_valid), 32'd0);
        drive_idle();

        // Load-use bubble, then accept with MEM/WB forwarding
        id_valid = 1'b1; id_rd = 5'd3; id_mem_read = 1'b1; id_reg_write = 1'b1;
        step();
        id_mem_read = 1'b0; id_rd = 5'd8; id_rs1 = 5'd1; id_rs2 = 5'd3; id_rs2_data = 32'hDEAD0000;
        #1 chk("lu_ready", 32'(id_ready), 32'd0);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h00005A5A;
        #1 chk("lu_accept", 32'(id_ready), 32'd1);
        step();
        id_valid = 1'b0;
        #1 chk("lu_fwd_b", alu_b, 32'h00005A5A); chk("lu_v", 32'(ex_valid), 32'd1);
        step();
        drive_idle();

        // PC and immediate operands
        id_valid = 1'b1; id_use_pc = 1'b1; id_pc = 32'h00000100; id_use_imm = 1'b1;
        id_imm = 32'hFFFFFFFC; id_alu_sel = 4'd9;
        step();
        id_valid = 1'b0;
        #1 chk("imm_a", alu_a, 32'h00000100); chk("imm_b", alu_b, 32'hFFFFFFFC); chk("imm_sel", 32'(alu_sel), 32'd9);
        step();

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst = 1'b1;
                #1 chk("rst_v", 32'(ex_valid), 32'd0); chk("rst_sel", 32'(alu_sel), 32'd0);
                chk("rst_rw", 32'(ex_reg_write), 32'd0);
                model_reset();
                @(posedge clk);
                #1 rst = 1'b0;
            end
            id_valid = ($urandom_range(0, 3) != 0);
            id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
            id_alu_sel = 4'($urandom_range(0, 9));
            id_use_pc = 1'($urandom_range(0, 1)); id_use_imm = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 9) == 0); ex_ready = ($urandom_range(0, 3) != 0);
            exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
